sobel_window_3x3: RTL and testbench
===================================

# sobel_window_3x3

Streaming 3×3 neighbourhood generator directly upstream of the Sobel edge stage. Accepts one 8-bit grey pixel per qualified cycle in raster order, keeps the two previous rows in line buffers, and presents the full window as z0..z8 with a valid strobe. Window order is z0 top-left, z1 top-centre, z2 top-right, z3..z5 middle row, z6..z8 bottom row. Only fully interior windows are emitted, so the edge stage sees an (W−2)×(H−2) image.

## Interface
- WIDTH, 640, pixels per line (3..1024)
- HEIGHT, 480, lines per frame (3..1024)
- CW, 10, coordinate width
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- pix_in  in  8  input pixel
- pix_valid  in  1  pixel qualifier; one pixel accepted per high cycle
- sof  in  1  start of frame; meaningful only with pix_valid; marks pixel (0,0)
- z0..z8  out  8 each  window pixels
- win_valid  out  1  window on z0..z8 is new this cycle
- cx, cy  out  CW each  image coordinates of window centre (z4)
- frame_done  out  1  one-cycle pulse after the last pixel (HEIGHT−1, WIDTH−1) is accepted

## Operation
- FSM: IDLE, ACTIVE. Reset → IDLE. IDLE: pixels without sof ignored; pix_valid&sof → ACTIVE, pixel is (0,0).
- ACTIVE: each accepted pixel advances col; col==WIDTH−1 wraps to 0 and increments row. Accepting (HEIGHT−1, WIDTH−1) without sof → IDLE and frame_done next cycle.
- pix_valid&sof in ACTIVE (including on the last pixel): restart; pixel becomes (0,0); no frame_done.
- Line buffers lb1 (row r−1), lb2 (row r−2), WIDTH×8 each, addressed by col. On accept: tap1=lb1[col], tap2=lb2[col] (old contents); write lb2[col]←tap1, lb1[col]←pix_in.
- Window shift on accept only: z0←z1, z1←z2, z2←tap2; z3←z4, z4←z5, z5←tap1; z6←z7, z7←z8, z8←pix_in.
- win_valid registered: set for an accepted pixel at (r,c) with r≥2 and c≥2; then cx=c−1, cy=r−1.
- Windows never span a line wrap or a frame boundary; stale line-buffer data is masked by the r≥2 condition, so buffers are not cleared on reset or sof.
- pix_valid low: z, cx, cy hold; win_valid=0.

## Timing
- Latency: pixel accepted cycle N → window containing it as z8 valid cycle N+1.
- At cycle N+1: z8=(r,c), z7=(r,c−1), z6=(r,c−2), z5=(r−1,c), z2=(r−2,c), z0=(r−2,c−2).
- Throughput 1 window/cycle; no backpressure; the edge stage must accept every win_valid.
- Reset values: z0..z8=0, win_valid=0, cx=cy=0, frame_done=0, row=col=0, state IDLE. Reset mid-frame discards the frame; pixels with reset high are ignored; after release a new sof is required.
- frame_done and a final win_valid for the same pixel coincide at cycle N+1.

## Structure
- Package sobel_pkg: PIX_W=8, default WIDTH/HEIGHT, CW, FSM state enum.
- Sub-module line_buffer (depth WIDTH, 8 bits, single address, read-old-on-write, distributed or BRAM with write-first disabled); instantiated twice.
- Counters, FSM, window registers and valid/coordinate logic in the top.

## Test plan
- Ramp, WIDTH=8, HEIGHT=6, pix=16·r+c, pix_valid continuous: first win_valid one cycle after pixel (2,2); z0..z8=00,01,02,10,11,12,20,21,22; cx=1, cy=1; exactly 24 windows; last window z8=0x57, cx=6, cy=4.
- Same ramp with random pix_valid gaps (~40% idle): identical window sequence; z/cx/cy held on idle cycles; win_valid never high on idle cycles.
- End of frame: frame_done single pulse one cycle after (5,7); 5 extra pixels without sof yield no windows; next sof frame reproduces scenario 1 exactly.
- sof asserted at pixel (3,4) mid-frame: that pixel is (0,0); no win_valid until new (2,2); first window equals the new frame's data only.
- reset for 2 cycles at pixel (4,3): outputs all 0 the cycle after reset; pixels during reset ignored; no output until sof; following frame matches scenario 1.
- WIDTH=3, HEIGHT=3 corner: exactly one window, cx=cy=1, frame_done in the same cycle as win_valid.

Source files
------------

// File: rtl/sobel_pkg.sv
// ----------------------------------------------------------------------------
// sobel_pkg
// Shared constants and types for the 3x3 Sobel window generator.
//   PIX_W       : grey pixel width
//   DEF_WIDTH   : default pixels per line
//   DEF_HEIGHT  : default lines per frame
//   DEF_CW      : default coordinate width
//   state_e     : frame-tracking FSM states
// ----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W      = 8;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_CW     = 10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage : sobel_pkg

// File: rtl/line_buffer.sv
// ----------------------------------------------------------------------------
// line_buffer
// One image line of pixel storage, single address port. The read is
// combinational, so during a write cycle rdata_o returns the old contents
// (read-before-write); a write-first RAM must not be used here.
// Ports:
//   clock    in  system clock
//   we_i     in  write enable
//   addr_i   in  column address
//   wdata_i  in  pixel to store
//   rdata_o  out pixel currently stored at addr_i
// ----------------------------------------------------------------------------
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int DW    = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    // NOTE: storage is deliberately not reset; stale contents are masked
    // downstream and a reset port would prevent RAM inference.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : line_buffer

// File: rtl/sobel_window_3x3.sv
// ----------------------------------------------------------------------------
// sobel_window_3x3
// Streaming 3x3 neighbourhood generator. Pixels arrive in raster order; two
// line buffers hold rows r-1 and r-2 and a 3x3 shift register presents the
// window. Only fully interior windows are flagged, so downstream sees a
// (WIDTH-2)x(HEIGHT-2) image.
// Ports:
//   clock       in  system clock, all logic on posedge
//   reset       in  synchronous active-high reset
//   pix_in      in  input pixel
//   pix_valid   in  one pixel accepted per high cycle
//   sof         in  start of frame, qualified by pix_valid, marks pixel (0,0)
//   z0..z8      out window, z0 top-left .. z8 bottom-right (newest pixel)
//   win_valid   out window is new this cycle
//   cx, cy      out coordinates of the window centre z4
//   frame_done  out one-cycle pulse after the last pixel of a frame
// ----------------------------------------------------------------------------
module sobel_window_3x3
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int CW     = DEF_CW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] z0,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic [PIX_W-1:0] z7,
    output logic [PIX_W-1:0] z8,
    output logic             win_valid,
    output logic [CW-1:0]    cx,
    output logic [CW-1:0]    cy,
    output logic             frame_done
);

    localparam int          AW       = $clog2(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(HEIGHT - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    row_q, row_d;

    logic             restart;
    logic             accept;
    logic             last_pix;
    logic [CW-1:0]    cur_col;
    logic [CW-1:0]    cur_row;

    logic [PIX_W-1:0] tap1, tap2;
    logic [PIX_W-1:0] win_q [9];
    logic             win_valid_q, win_valid_d;
    logic [CW-1:0]    cx_q, cx_d;
    logic [CW-1:0]    cy_q, cy_d;
    logic             frame_done_q;

    // ------------------------------------------------------------------
    // FSM state and position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would infer a latch.
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;

        unique case (state_q)
            ST_IDLE:   if (restart)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (last_pix) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (last_pix) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // Datapath control derived from the current state and inputs.
    // A sof pixel is always (0,0), even in the middle of a frame.
    always_comb begin
        restart  = pix_valid & sof;
        accept   = pix_valid & (restart | (state_q == ST_ACTIVE));
        cur_col  = restart ? '0 : col_q;
        cur_row  = restart ? '0 : row_q;
        last_pix = accept & ~restart & (cur_row == ROW_LAST) & (cur_col == COL_LAST);

        win_valid_d = accept & (cur_row >= TWO) & (cur_col >= TWO);
        cx_d        = cur_col - 1'b1;
        cy_d        = cur_row - 1'b1;
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row r-1, lb2 holds row r-2. The row-r-1
    // pixel read out of lb1 ages into lb2 at the same address.
    // ------------------------------------------------------------------
    line_buffer #(
        .DEPTH (WIDTH),
        .DW    (PIX_W),
        .AW    (AW)
    ) u_lb1 (
        .clock   (clock),
        .we_i    (accept & ~reset),
        .addr_i  (cur_col[AW-1:0]),
        .wdata_i (pix_in),
        .rdata_o (tap1)
    );

    line_buffer #(
        .DEPTH (WIDTH),
        .DW    (PIX_W),
        .AW    (AW)
    ) u_lb2 (
        .clock   (clock),
        .we_i    (accept & ~reset),
        .addr_i  (cur_col[AW-1:0]),
        .wdata_i (tap1),
        .rdata_o (tap2)
    );

    // ------------------------------------------------------------------
    // Window shift register and output qualifiers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            win_valid_q  <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= win_valid_d;
            frame_done_q <= last_pix;
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= tap2;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= tap1;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= pix_in;
            end
            // Coordinates only move with a valid window so they stay
            // aligned with the last window the edge stage consumed.
            if (win_valid_d) begin
                cx_q <= cx_d;
                cy_q <= cy_d;
            end
        end
    end

    assign z0         = win_q[0];
    assign z1         = win_q[1];
    assign z2         = win_q[2];
    assign z3         = win_q[3];
    assign z4         = win_q[4];
    assign z5         = win_q[5];
    assign z6         = win_q[6];
    assign z7         = win_q[7];
    assign z8         = win_q[8];
    assign win_valid  = win_valid_q;
    assign cx         = cx_q;
    assign cy         = cy_q;
    assign frame_done = frame_done_q;

endmodule : sobel_window_3x3

// File: tb/tb_sobel_window_3x3.sv
module tb_sobel_window_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main DUT (8x6)
    logic          reset;
    logic [7:0]    pix_in;
    logic          pix_valid, sof;
    logic [7:0]    z0, z1, z2, z3, z4, z5, z6, z7, z8;
    logic          win_valid, frame_done;
    logic [CW-1:0] cx, cy;
    logic [71:0]   z_all;
    assign z_all = {z0, z1, z2, z3, z4, z5, z6, z7, z8};

    // Corner DUT (3x3)
    logic [7:0]    c_pix;
    logic          c_valid, c_sof;
    logic [7:0]    cz0, cz1, cz2, cz3, cz4, cz5, cz6, cz7, cz8;
    logic          c_wv, c_fd;
    logic [CW-1:0] c_cx, c_cy;
    logic [71:0]   cz_all;
    assign cz_all = {cz0, cz1, cz2, cz3, cz4, cz5, cz6, cz7, cz8};

    sobel_window_3x3 #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
        .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8),
        .win_valid(win_valid), .cx(cx), .cy(cy), .frame_done(frame_done)
    );

    sobel_window_3x3 #(.WIDTH(3), .HEIGHT(3), .CW(CW)) dut_corner (
        .clock(clock), .reset(reset), .pix_in(c_pix), .pix_valid(c_valid), .sof(c_sof),
        .z0(cz0), .z1(cz1), .z2(cz2), .z3(cz3), .z4(cz4), .z5(cz5), .z6(cz6), .z7(cz7), .z8(cz8),
        .win_valid(c_wv), .cx(c_cx), .cy(c_cy), .frame_done(c_fd)
    );

    typedef struct packed {
        logic [71:0]   z;
        logic [CW-1:0] cx;
        logic [CW-1:0] cy;
        logic [7:0]    src;   // pixel driven in the cycle that produced the window
    } win_t;

    win_t        obs_q[$];
    int          n_vec    = 0;
    int          n_err    = 0;
    int          idle_bad = 0;
    int          fd_count = 0;
    logic [7:0]  fd_src;
    logic [91:0] prev_out;

    function automatic logic [7:0] pv(int r, int c);
        return 8'(16 * r + c);
    endfunction

    function automatic win_t exp_win(int r, int c);
        win_t w;
        w.z   = {pv(r-2, c-2), pv(r-2, c-1), pv(r-2, c),
                 pv(r-1, c-2), pv(r-1, c-1), pv(r-1, c),
                 pv(r,   c-2), pv(r,   c-1), pv(r,   c)};
        w.cx  = CW'(c - 1);
        w.cy  = CW'(r - 1);
        w.src = pv(r, c);
        return w;
    endfunction

    // Number of differences between the recorded windows and a clean ramp frame.
    function automatic int seq_errs();
        int e = 0;
        int k = 0;
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                if (k >= obs_q.size()) e++;
                else if (obs_q[k] !== exp_win(r, c)) e++;
                k++;
            end
        end
        if (obs_q.size() != k) e++;
        return e;
    endfunction

    // Drive one cycle on the main DUT and record what it produced.
    task automatic step(input logic [7:0] p, input logic v, input logic s);
        win_t w;
        @(negedge clock);
        pix_in = p; pix_valid = v; sof = s;
        @(posedge clock);
        #1;
        if (!v && !reset) begin
            if (win_valid !== 1'b0) idle_bad++;
            if ({z_all, cx, cy} !== prev_out) idle_bad++;
        end
        if (win_valid === 1'b1) begin
            w.z = z_all; w.cx = cx; w.cy = cy; w.src = p;
            obs_q.push_back(w);
        end
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_src = p;
        end
        prev_out = {z_all, cx, cy};
    endtask

    task automatic play_frame(input int gap_pct);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) < gap_pct) step(8'($urandom_range(255)), 1'b0, 1'b0);
                step(pv(r, c), 1'b1, (r == 0 && c == 0));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; pix_valid = 1'b1; sof = 1'b1; pix_in = 8'h55;
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        if ({z_all, cx, cy, win_valid, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {z_all, cx, cy, win_valid, frame_done});
        end
        n_vec++;
        if ({cz_all, c_cx, c_cy, c_wv, c_fd} !== '0) begin
            n_err++;
            $display("FAIL reset_corner_outputs: got %h want 0", {cz_all, c_cx, c_cy, c_wv, c_fd});
        end
        @(negedge clock);
        reset = 1'b0; pix_valid = 1'b0; sof = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 3; i++) step(8'h11 + 8'(i), 1'b1, 1'b0);
        n_vec++;
        if (obs_q.size() != 0 || z_all !== '0) begin
            n_err++;
            $display("FAIL idle_no_sof: got windows=%0d z=%h want 0 and 0", obs_q.size(), z_all);
        end
    endtask

    task automatic test_ramp();
        obs_q.delete(); fd_count = 0;
        play_frame(0);
        n_vec++;
        if (obs_q.size() != 24) begin
            n_err++;
            $display("FAIL ramp_count: got %0d want 24", obs_q.size());
        end
        n_vec++;
        if (obs_q.size() == 0 || obs_q[0] !== exp_win(2, 2)) begin
            n_err++;
            $display("FAIL ramp_first: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : '0, exp_win(2, 2));
        end
        n_vec++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== exp_win(5, 7)) begin
            n_err++;
            $display("FAIL ramp_last: got %h want %h", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : '0, exp_win(5, 7));
        end
        n_vec++;
        if (seq_errs() != 0) begin
            n_err++;
            $display("FAIL ramp_sequence: got %0d bad windows want 0", seq_errs());
        end
        n_vec++;
        if (fd_count != 1 || fd_src !== pv(5, 7)) begin
            n_err++;
            $display("FAIL ramp_frame_done: got count=%0d src=%h want 1 and %h", fd_count, fd_src, pv(5, 7));
        end
    endtask

    task automatic test_gaps();
        obs_q.delete(); fd_count = 0; idle_bad = 0;
        play_frame(40);
        n_vec++;
        if (seq_errs() != 0) begin
            n_err++;
            $display("FAIL gaps_sequence: got %0d bad windows want 0", seq_errs());
        end
        n_vec++;
        if (idle_bad != 0) begin
            n_err++;
            $display("FAIL gaps_idle_hold: got %0d violations want 0", idle_bad);
        end
        n_vec++;
        if (fd_count != 1) begin
            n_err++;
            $display("FAIL gaps_frame_done: got %0d want 1", fd_count);
        end
    endtask

    task automatic test_end_of_frame();
        obs_q.delete(); fd_count = 0;
        play_frame(0);
        step(8'h00, 1'b0, 1'b0);
        n_vec++;
        if (fd_count != 1 || fd_src !== pv(5, 7)) begin
            n_err++;
            $display("FAIL eof_pulse: got count=%0d src=%h want 1 and %h", fd_count, fd_src, pv(5, 7));
        end
        for (int i = 0; i < 5; i++) step(8'h99, 1'b1, 1'b0);
        n_vec++;
        if (obs_q.size() != 24 || fd_count != 1) begin
            n_err++;
            $display("FAIL eof_extra_pixels: got windows=%0d fd=%0d want 24 and 1", obs_q.size(), fd_count);
        end
        obs_q.delete();
        play_frame(0);
        n_vec++;
        if (seq_errs() != 0) begin
            n_err++;
            $display("FAIL eof_next_frame: got %0d bad windows want 0", seq_errs());
        end
    endtask

    task automatic test_sof_restart();
        obs_q.delete();
        begin : old_frame
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r == 3 && c == 4) disable old_frame;
                    step(8'hE0 ^ 8'(r * W + c), 1'b1, (r == 0 && c == 0));
                end
            end
        end
        obs_q.delete(); fd_count = 0;
        play_frame(0);
        n_vec++;
        if (seq_errs() != 0) begin
            n_err++;
            $display("FAIL sof_restart_sequence: got %0d bad windows want 0", seq_errs());
        end
        n_vec++;
        if (fd_count != 1) begin
            n_err++;
            $display("FAIL sof_restart_frame_done: got %0d want 1", fd_count);
        end
    endtask

    task automatic test_reset_mid();
        begin : part_frame
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r == 4 && c == 3) disable part_frame;
                    step(pv(r, c), 1'b1, (r == 0 && c == 0));
                end
            end
        end
        @(negedge clock);
        reset = 1'b1; pix_valid = 1'b1; sof = 1'b1; pix_in = 8'h77;
        @(negedge clock);
        sof = 1'b0; pix_in = 8'h78;
        @(negedge clock);
        reset = 1'b0; pix_valid = 1'b0;
        #1;
        n_vec++;
        if ({z_all, cx, cy, win_valid, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h want 0", {z_all, cx, cy, win_valid, frame_done});
        end
        prev_out = {z_all, cx, cy};
        obs_q.delete(); fd_count = 0;
        for (int i = 0; i < 4; i++) step(8'h30 + 8'(i), 1'b1, 1'b0);
        n_vec++;
        if (obs_q.size() != 0 || {z_all, cx, cy, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_needs_sof: got windows=%0d out=%h want 0 and 0", obs_q.size(), {z_all, cx, cy, frame_done});
        end
        play_frame(0);
        n_vec++;
        if (seq_errs() != 0) begin
            n_err++;
            $display("FAIL reset_mid_next_frame: got %0d bad windows want 0", seq_errs());
        end
    endtask

    task automatic test_corner();
        int          n_win = 0;
        logic        last_wv, last_fd;
        logic [71:0] last_z;
        logic [CW-1:0] last_cx, last_cy;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                c_pix = pv(r, c); c_valid = 1'b1; c_sof = (r == 0 && c == 0);
                @(posedge clock);
                #1;
                if (c_wv === 1'b1) n_win++;
                last_wv = c_wv; last_fd = c_fd; last_z = cz_all; last_cx = c_cx; last_cy = c_cy;
            end
        end
        @(negedge clock);
        c_valid = 1'b0; c_sof = 1'b0;
        @(posedge clock);
        #1;
        if (c_wv === 1'b1) n_win++;
        n_vec++;
        if (n_win != 1) begin
            n_err++;
            $display("FAIL corner_count: got %0d want 1", n_win);
        end
        n_vec++;
        if ({last_wv, last_fd} !== 2'b11) begin
            n_err++;
            $display("FAIL corner_coincide: got wv=%b fd=%b want 1 1", last_wv, last_fd);
        end
        n_vec++;
        if (last_z !== 72'h00_01_02_10_11_12_20_21_22 || last_cx !== CW'(1) || last_cy !== CW'(1)) begin
            n_err++;
            $display("FAIL corner_window: got z=%h cx=%0d cy=%0d want 000102101112202122 1 1", last_z, last_cx, last_cy);
        end
        n_vec++;
        if (c_fd !== 1'b0) begin
            n_err++;
            $display("FAIL corner_pulse_width: got %b want 0", c_fd);
        end
    endtask

    initial begin
        reset = 1'b1; pix_in = '0; pix_valid = 1'b0; sof = 1'b0;
        c_pix = '0; c_valid = 1'b0; c_sof = 1'b0;
        prev_out = '0;
        test_reset();
        test_ramp();
        test_gaps();
        test_end_of_frame();
        test_sof_restart();
        test_reset_mid();
        test_corner();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sobel_window_3x3
